// File: rtl/ov7670_dvp_emulator_if.sv
// DVP pixel bus between the OV7670 emulator (master) and a capture block (slave).
interface ov7670_dvp_emulator_if;
    logic       cam_vsync;
    logic       href;
    logic [7:0] p_data;

    modport master (output cam_vsync, href, p_data);
    modport slave  (input  cam_vsync, href, p_data);
endinterface

// File: rtl/ov7670_dvp_emulator.sv
// OV7670 DVP transmitter emulator producing RGB565 test patterns, high byte first.
// Define CAM_EMU_FRAME_TAG_EN to replace pixel (0,0) of each frame with frame_count.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | outputs low, waiting for enable
// S_VSYNC  | cam_vsync high for VSYNC_LINES line periods
// S_VBP    | V_BACK_PORCH blank line periods
// S_ACTIVE | FRAME_HEIGHT lines of 2*FRAME_WIDTH bytes plus H_BLANK gap
// S_VFP    | V_FRONT_PORCH blank line periods
module ov7670_dvp_emulator #(
    parameter int FRAME_WIDTH   = 640,
    parameter int FRAME_HEIGHT  = 480,
    parameter int H_BLANK       = 144,
    parameter int VSYNC_LINES   = 3,
    parameter int V_BACK_PORCH  = 17,
    parameter int V_FRONT_PORCH = 10
) (
    input  logic                         PixelClk,
    input  logic                         nRST,
    input  logic                         enable,
    input  logic [1:0]                   pattern_mode,
    input  logic [15:0]                  solid_color,
    ov7670_dvp_emulator_if.master        dvp,
    output logic                         frame_start,
    output logic [15:0]                  frame_count,
    output logic                         busy
);
    localparam int LP        = 2 * FRAME_WIDTH + H_BLANK;
    localparam int COL_W     = $clog2(LP);
    localparam int MAX_A     = (VSYNC_LINES > FRAME_HEIGHT) ? VSYNC_LINES : FRAME_HEIGHT;
    localparam int MAX_B     = (V_BACK_PORCH > V_FRONT_PORCH) ? V_BACK_PORCH : V_FRONT_PORCH;
    localparam int MAX_L     = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int LINE_W    = (MAX_L > 1) ? $clog2(MAX_L) : 1;
    localparam int BAR_W     = FRAME_WIDTH / 8;
    localparam int BP_W      = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(LP - 1);
    localparam logic [COL_W-1:0]  COL_ACT  = COL_W'(2 * FRAME_WIDTH);
    localparam logic [LINE_W-1:0] VS_LAST  = LINE_W'(VSYNC_LINES - 1);
    localparam logic [LINE_W-1:0] VBP_LAST = LINE_W'((V_BACK_PORCH > 0) ? V_BACK_PORCH - 1 : 0);
    localparam logic [LINE_W-1:0] ACT_LAST = LINE_W'(FRAME_HEIGHT - 1);
    localparam logic [LINE_W-1:0] VFP_LAST = LINE_W'((V_FRONT_PORCH > 0) ? V_FRONT_PORCH - 1 : 0);
    localparam logic [BP_W-1:0]   BP_LAST  = BP_W'(BAR_W - 1);

    typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_VBP, S_ACTIVE, S_VFP} state_t;

    state_t              state, state_n;
    logic [COL_W-1:0]    col, col_n;
    logic [LINE_W-1:0]   line, line_n, last_line;
    logic [BP_W-1:0]     bar_pix, bar_pix_n;
    logic [2:0]          bar_idx, bar_idx_n;
    logic [1:0]          mode_q;
    logic [15:0]         solid_q;
    logic                start, frame_done, act_n;
    logic [15:0]         x, y, pix;

    // Next-cycle position; outputs are registered from these so they line up with the state.
    always_comb begin
        state_n    = state;
        col_n      = col;
        line_n     = line;
        start      = 1'b0;
        frame_done = 1'b0;
        case (state)
            S_VSYNC:  last_line = VS_LAST;
            S_VBP:    last_line = VBP_LAST;
            S_ACTIVE: last_line = ACT_LAST;
            S_VFP:    last_line = VFP_LAST;
            default:  last_line = '0;
        endcase
        if (state == S_IDLE) begin
            if (enable) begin
                state_n = S_VSYNC;
                start   = 1'b1;
            end
        end else if (col != COL_LAST) begin
            col_n = col + 1'b1;
        end else begin
            col_n = '0;
            if (line != last_line) begin
                line_n = line + 1'b1;
            end else begin
                line_n = '0;
                case (state)
                    S_VSYNC:  state_n = (V_BACK_PORCH > 0) ? S_VBP : S_ACTIVE;
                    S_VBP:    state_n = S_ACTIVE;
                    S_ACTIVE: if (V_FRONT_PORCH > 0) state_n = S_VFP;
                              else frame_done = 1'b1;
                    default:  frame_done = 1'b1;
                endcase
                if (frame_done) begin
                    state_n = enable ? S_VSYNC : S_IDLE;
                    start   = enable;
                end
            end
        end
    end

    // Colour bar index tracked by a per-pixel counter instead of dividing the column.
    always_comb begin
        bar_pix_n = bar_pix;
        bar_idx_n = bar_idx;
        if (col_n == '0) begin
            bar_pix_n = '0;
            bar_idx_n = '0;
        end else if (!col_n[0] && col_n < COL_ACT) begin
            if (bar_pix == BP_LAST) begin
                bar_pix_n = '0;
                bar_idx_n = bar_idx + 3'd1;
            end else begin
                bar_pix_n = bar_pix + 1'b1;
            end
        end
    end

    always_comb begin
        act_n = (state_n == S_ACTIVE) && (col_n < COL_ACT);
        x     = 16'(col_n >> 1);
        y     = 16'(line_n);
        case (mode_q)
            2'd0: pix = x + (y << 8);
            2'd1: begin
                case (bar_idx_n)
                    3'd0:    pix = 16'hFFFF;
                    3'd1:    pix = 16'hFFE0;
                    3'd2:    pix = 16'h07FF;
                    3'd3:    pix = 16'h07E0;
                    3'd4:    pix = 16'hF81F;
                    3'd5:    pix = 16'hF800;
                    3'd6:    pix = 16'h001F;
                    default: pix = 16'h0000;
                endcase
            end
            2'd2:    pix = solid_q;
            default: pix = (x[4] ^ y[4]) ? 16'hFFFF : 16'h0000;
        endcase
`ifdef CAM_EMU_FRAME_TAG_EN
        if (col_n < COL_W'(2) && line_n == '0) pix = frame_count;
`else
`endif
    end

    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            state         <= S_IDLE;
            col           <= '0;
            line          <= '0;
            bar_pix       <= '0;
            bar_idx       <= '0;
            mode_q        <= '0;
            solid_q       <= '0;
            frame_start   <= 1'b0;
            frame_count   <= '0;
            busy          <= 1'b0;
            dvp.cam_vsync <= 1'b0;
            dvp.href      <= 1'b0;
            dvp.p_data    <= '0;
        end else begin
            state         <= state_n;
            col           <= col_n;
            line          <= line_n;
            bar_pix       <= bar_pix_n;
            bar_idx       <= bar_idx_n;
            frame_start   <= start;
            busy          <= (state_n != S_IDLE);
            dvp.cam_vsync <= (state_n == S_VSYNC);
            dvp.href      <= act_n;
            dvp.p_data    <= act_n ? (col_n[0] ? pix[7:0] : pix[15:8]) : 8'h00;
            if (start) begin
                frame_count <= frame_count + 16'd1;
                mode_q      <= pattern_mode;
                solid_q     <= solid_color;
            end
        end
    end
endmodule

// File: tb/tb_ov7670_dvp_emulator.sv
// Scoreboard bench for ov7670_dvp_emulator: expected frame bytes queued at stimulus time, timing from frame arithmetic.
module tb_ov7670_dvp_emulator;
    localparam int FW  = 8;
    localparam int FH  = 4;
    localparam int HB  = 4;
    localparam int VS  = 2;
    localparam int VBP = 1;
    localparam int VFP = 1;
    localparam int LP  = 2 * FW + HB;
    localparam int FRAME_CYC = (VS + VBP + FH + VFP) * LP;
    localparam int N_FRAMES  = 12;

    logic        PixelClk = 1'b0;
    logic        nRST;
    logic        enable;
    logic [1:0]  pattern_mode;
    logic [15:0] solid_color;
    logic        frame_start;
    logic [15:0] frame_count;
    logic        busy;

    ov7670_dvp_emulator_if dvp();

    ov7670_dvp_emulator #(
        .FRAME_WIDTH(FW), .FRAME_HEIGHT(FH), .H_BLANK(HB),
        .VSYNC_LINES(VS), .V_BACK_PORCH(VBP), .V_FRONT_PORCH(VFP)
    ) dut (
        .PixelClk(PixelClk), .nRST(nRST), .enable(enable),
        .pattern_mode(pattern_mode), .solid_color(solid_color),
        .dvp(dvp), .frame_start(frame_start), .frame_count(frame_count), .busy(busy)
    );

    always #5 PixelClk = ~PixelClk;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    int frames_issued;
    int dir_modes[8] = '{0, 1, 1, 2, 2, 3, 3, 3};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [15:0] model_pixel(input int mode, input logic [15:0] solid,
                                                input int x, input int y, input int fnum);
        logic [15:0] p;
        case (mode)
            0: p = 16'((x + 256 * y) % 65536);
            1: begin
                case (x / (FW / 8))
                    0: p = 16'hFFFF;  1: p = 16'hFFE0;  2: p = 16'h07FF;  3: p = 16'h07E0;
                    4: p = 16'hF81F;  5: p = 16'hF800;  6: p = 16'h001F;  default: p = 16'h0000;
                endcase
            end
            2: p = solid;
            default: p = (((x >> 4) ^ (y >> 4)) & 1) != 0 ? 16'hFFFF : 16'h0000;
        endcase
`ifdef CAM_EMU_FRAME_TAG_EN
        if (x == 0 && y == 0) p = 16'(fnum);
`else
        if (fnum < 0) p = 16'h0000;
`endif
        return p;
    endfunction

    task automatic tick();
        @(posedge PixelClk);
        #2;
    endtask

    task automatic set_frame(input int mode, input logic [15:0] solid);
        logic [15:0] p;
        pattern_mode = 2'(mode);
        solid_color  = solid;
        frames_issued++;
        for (int yy = 0; yy < FH; yy++)
            for (int xx = 0; xx < FW; xx++) begin
                p = model_pixel(mode, solid, xx, yy, frames_issued);
                exp_q.push_back(p[15:8]);
                exp_q.push_back(p[7:0]);
            end
    endtask

    task automatic wait_start(input int budget);
        bit found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            tick();
            if (frame_start) found = 1'b1;
        end
        check("frame_start_seen", 32'(found), 32'd1);
    endtask

    // Monitor: timing from frame-relative cycle arithmetic, bytes from the scoreboard queue.
    initial begin : monitor
        bit   pend, in_frame, ev, eh;
        int   t, mframes, ln, cl;
        logic [7:0] eb;
        pend = 1'b0; in_frame = 1'b0; t = 0; mframes = 0;
        forever begin
            @(negedge PixelClk);
            if (!nRST) begin
                pend = 1'b0; in_frame = 1'b0; t = 0; mframes = 0;
                continue;
            end
            check("frame_start", 32'(frame_start), 32'(pend));
            if (pend) begin
                in_frame = 1'b1;
                t = 0;
                mframes++;
                check("frame_count", 32'(frame_count), 32'(mframes % 65536));
            end else if (in_frame) begin
                t++;
                if (t == FRAME_CYC) in_frame = 1'b0;
            end
            ev = 1'b0; eh = 1'b0;
            if (in_frame) begin
                ln = t / LP;
                cl = t % LP;
                ev = (ln < VS);
                eh = (ln >= VS + VBP) && (ln < VS + VBP + FH) && (cl < 2 * FW);
            end
            check("cam_vsync", 32'(dvp.cam_vsync), 32'(ev));
            check("href", 32'(dvp.href), 32'(eh));
            check("busy", 32'(busy), 32'(in_frame));
            if (dvp.href) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL byte_queue actual=empty required=expected byte");
                end else begin
                    eb = exp_q.pop_front();
                    check("p_data", 32'(dvp.p_data), 32'(eb));
                end
            end else begin
                check("p_data_idle", 32'(dvp.p_data), 32'd0);
            end
            pend = enable && (!in_frame || t == FRAME_CYC - 1);
        end
    end

    initial begin : driver
        int k, m;
        logic [15:0] s;
        nRST = 1'b0; enable = 1'b0; pattern_mode = 2'd0; solid_color = 16'h0; frames_issued = 0;
        repeat (3) tick();
        check("rst_vsync", 32'(dvp.cam_vsync), 32'd0);
        check("rst_href", 32'(dvp.href), 32'd0);
        check("rst_p_data", 32'(dvp.p_data), 32'd0);
        check("rst_frame_count", 32'(frame_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        nRST = 1'b1;
        repeat (3) tick();

        // Back-to-back frames; next frame's settings change at a random point of the current one.
        set_frame(0, 16'h0);
        enable = 1'b1;
        for (int i = 0; i < N_FRAMES; i++) begin
            wait_start(FRAME_CYC + 10);
            if (i < N_FRAMES - 1) begin
                k = $urandom_range(150, 5);
                repeat (k) tick();
                m = (i + 1 < 8) ? dir_modes[i + 1] : int'($urandom_range(3, 0));
                s = (i + 1 == 3) ? 16'h1234 : (i + 1 == 4) ? 16'hABCD : 16'($urandom);
                set_frame(m, s);
            end else begin
                repeat (50) tick();
                enable = 1'b0;
            end
        end
        repeat (FRAME_CYC + 20) tick();

        // Reset during an active line, then restart.
        set_frame(int'($urandom_range(3, 0)), 16'($urandom));
        enable = 1'b1;
        wait_start(FRAME_CYC + 10);
        repeat (90) tick();
        check("href_before_reset", 32'(dvp.href), 32'd1);
        nRST = 1'b0;
        #1;
        check("mid_rst_href", 32'(dvp.href), 32'd0);
        check("mid_rst_vsync", 32'(dvp.cam_vsync), 32'd0);
        check("mid_rst_p_data", 32'(dvp.p_data), 32'd0);
        check("mid_rst_frame_count", 32'(frame_count), 32'd0);
        exp_q.delete();
        frames_issued = 0;
        enable = 1'b0;
        repeat (3) tick();
        nRST = 1'b1;
        repeat (2) tick();
        set_frame(int'($urandom_range(3, 0)), 16'($urandom));
        enable = 1'b1;
        wait_start(FRAME_CYC + 10);
        check("restart_frame_count", 32'(frame_count), 32'd1);
        repeat (50) tick();
        enable = 1'b0;
        repeat (FRAME_CYC + 20) tick();
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
